// File: rtl/display_pkg.sv
// display_pkg -- shared types and helpers for the 4-digit display scanner.
//   scan_state_t : scanner FSM states (BLANK dead-time, SHOW digit lit)
//   scan_out_t   : bundle of registered scanner outputs
//   onehot()     : digit index -> one-hot digit enable
//   cnt_w()      : prescaler width able to hold the longest slot length
package display_pkg;

  localparam int DIGITS   = 4;
  localparam int NIBBLE_W = 4;
  localparam int IDX_W    = 2;
  localparam int VAL_W    = DIGITS * NIBBLE_W;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [NIBBLE_W-1:0] nibble;
    logic [DIGITS-1:0]   digit_en;
    logic                seg_en;
    logic                frame_done;
    logic                ready;
  } scan_out_t;

  // Output values held while in reset: everything dark, ready to accept.
  localparam scan_out_t SCAN_OUT_RST = '{
    nibble:     '0,
    digit_en:   '0,
    seg_en:     1'b0,
    frame_done: 1'b0,
    ready:      1'b1
  };

  function automatic logic [DIGITS-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Counter holds values 0..max(a,b)-1.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/display_prescaler.sv
// display_prescaler -- loadable down-counter with terminal-count flags.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   ld, ld_val : load ld_val on the next edge instead of counting
//   tc         : count is 0 this cycle
//   tc_nxt     : count will be 0 after the next edge (lets the parent
//                register a flag that lines up with tc)
// The counter parks at 0 when not reloaded.
module display_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         tc,
  output logic         tc_nxt
);

  logic [W-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (ld)             cnt_nxt = ld_val;
    else if (cnt != '0) cnt_nxt = cnt - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  assign tc     = (cnt == '0);
  assign tc_nxt = (cnt_nxt == '0);

endmodule

// File: rtl/display_scan_4digit.sv
// display_scan_4digit -- multiplexed 4-digit display scanner.
// Each digit slot is BLANK_CYC dead cycles followed by CLK_DIV lit cycles;
// a frame is four slots, digit0 first. New values are taken through a
// one-deep pending register and become visible only on a frame boundary so
// a frame never mixes two values.
//   input_clock1_clk_1   : clock
//   input_reset1_rst_n_2 : async active-low reset
//   input_data_value_3   : four nibbles, digit0 = [3:0]
//   input_data_valid_4   : value offered this cycle
//   output_data_ready_5  : pending register empty
//   input_switch_blank_6 : force all digit enables low
//   output_nibble_7      : current digit value for the segment decoder
//   output_digit_en_8    : one-hot digit enable
//   output_seg_en_9      : any digit enabled
//   output_frame_done_10 : one-cycle pulse on the last lit cycle of digit3
module display_scan_4digit
  import display_pkg::*;
#(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 16,
  parameter int LZB       = 1
) (
  input  logic                input_clock1_clk_1,
  input  logic                input_reset1_rst_n_2,
  input  logic [VAL_W-1:0]    input_data_value_3,
  input  logic                input_data_valid_4,
  output logic                output_data_ready_5,
  input  logic                input_switch_blank_6,
  output logic [NIBBLE_W-1:0] output_nibble_7,
  output logic [DIGITS-1:0]   output_digit_en_8,
  output logic                output_seg_en_9,
  output logic                output_frame_done_10
);

  localparam int CW = cnt_w(CLK_DIV, BLANK_CYC);

  logic clk, rst_n;
  assign clk   = input_clock1_clk_1;
  assign rst_n = input_reset1_rst_n_2;

  scan_state_t      state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             fresh;
  logic [VAL_W-1:0] active, active_n;
  logic [VAL_W-1:0] pending, pending_n;
  logic             pend_full, pend_full_n;
  scan_out_t        out_q, out_n;

  logic          ld, tc, tc_nxt;
  logic [CW-1:0] ld_val;
  logic          fd_now, xfer;

  display_prescaler #(.W(CW)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (ld),
    .ld_val (ld_val),
    .tc     (tc),
    .tc_nxt (tc_nxt)
  );

  // Leading-zero blanking: digit i is dark when it and every digit above it
  // are zero. Digit0 always lights so a zero value still shows "0".
  function automatic logic lz_sup(input logic [VAL_W-1:0] v,
                                  input logic [IDX_W-1:0] i);
    lz_sup = 1'b0;
    if (LZB != 0 && i != '0) begin
      lz_sup = 1'b1;
      for (int d = 1; d < DIGITS; d++)
        if (d >= int'(i) && v[NIBBLE_W*d +: NIBBLE_W] != '0) lz_sup = 1'b0;
    end
  endfunction

  // Slot sequencing. Reset leaves the counter at 0 in BLANK, and that first
  // cycle already counts as dead time, so the very first BLANK after reset
  // loads BLANK_CYC-2 to keep the slot BLANK_CYC cycles long.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    ld      = 1'b0;
    ld_val  = '0;
    unique case (state)
      BLANK: begin
        if (fresh && (BLANK_CYC > 1)) begin
          ld     = 1'b1;
          ld_val = CW'(BLANK_CYC - 2);
        end else if (tc) begin
          state_n = SHOW;
          ld      = 1'b1;
          ld_val  = CW'(CLK_DIV - 1);
        end
      end
      SHOW: begin
        if (tc) begin
          state_n = BLANK;
          idx_n   = idx + IDX_W'(1);
          ld      = 1'b1;
          ld_val  = CW'(BLANK_CYC - 1);
        end
      end
      default: state_n = BLANK;
    endcase
  end

  // Handshake and frame-boundary swap. While pending is full ready is low,
  // so a transfer and a swap can never collide.
  assign fd_now = (state == SHOW) && (idx == IDX_W'(DIGITS - 1)) && tc;
  assign xfer   = input_data_valid_4 && out_q.ready;

  always_comb begin
    pending_n   = pending;
    pend_full_n = pend_full;
    active_n    = active;
    if (fd_now && pend_full) begin
      active_n    = pending;
      pend_full_n = 1'b0;
    end
    if (xfer) begin
      pending_n   = input_data_value_3;
      pend_full_n = 1'b1;
    end
  end

  // Outputs are decoded from the next state so the registered outputs and
  // the state register always describe the same cycle.
  always_comb begin
    out_n            = '0;
    out_n.ready      = !pend_full_n;
    out_n.frame_done = (state_n == SHOW) && (idx_n == IDX_W'(DIGITS - 1)) && tc_nxt;
    if (state_n == SHOW) begin
      out_n.nibble = active_n[NIBBLE_W*idx_n +: NIBBLE_W];
      if (!input_switch_blank_6 && !lz_sup(active_n, idx_n))
        out_n.digit_en = onehot(idx_n);
    end
    out_n.seg_en = |out_n.digit_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BLANK;
      idx       <= '0;
      fresh     <= 1'b1;
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      out_q     <= SCAN_OUT_RST;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      fresh     <= 1'b0;
      active    <= active_n;
      pending   <= pending_n;
      pend_full <= pend_full_n;
      out_q     <= out_n;
    end
  end

  assign output_data_ready_5  = out_q.ready;
  assign output_nibble_7      = out_q.nibble;
  assign output_digit_en_8    = out_q.digit_en;
  assign output_seg_en_9      = out_q.seg_en;
  assign output_frame_done_10 = out_q.frame_done;

endmodule

// File: tb/tb_display_scan_4digit.sv
// Randomized bench for display_scan_4digit (CLK_DIV=4, BLANK_CYC=2, LZB=1).
// The driver issues random values, blank toggles and resets; for each cycle
// it asks a frame-position model what the outputs must be after the next
// edge and queues that. The monitor pops and compares after every edge.
module tb_display_scan_4digit;

  localparam int CLK_DIV   = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = CLK_DIV + BLANK_CYC;
  localparam int FRAME     = 4 * SLOT;
  localparam int NCYC      = 3000;
  localparam logic [10:0] RST_VEC = 11'b0000_0000_0_0_1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic        blank = 1'b0;
  logic [15:0] data  = '0;
  logic        ready, seg_en, fdone;
  logic [3:0]  nib, den;

  display_scan_4digit #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .LZB(1)) dut (
    .input_clock1_clk_1   (clk),
    .input_reset1_rst_n_2 (rst_n),
    .input_data_value_3   (data),
    .input_data_valid_4   (valid),
    .output_data_ready_5  (ready),
    .input_switch_blank_6 (blank),
    .output_nibble_7      (nib),
    .output_digit_en_8    (den),
    .output_seg_en_9      (seg_en),
    .output_frame_done_10 (fdone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [10:0] v;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within the frame plus the value registers.
  int          m_pos;
  logic [15:0] m_active, m_pending;
  logic        m_pfull;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got nib=%h en=%b seg=%b fd=%b rdy=%b, expected nib=%h en=%b seg=%b fd=%b rdy=%b",
               name, $time, act[10:7], act[6:3], act[2], act[1], act[0],
               exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Outputs at frame position p: first BLANK_CYC cycles of each slot dark,
  // then the slot's digit lit unless blanked or it is a leading zero.
  function automatic logic [10:0] model_out(input int p, input logic [15:0] act,
                                            input logic pf, input logic blk);
    int         slot, w;
    logic [3:0] n, e;
    logic [15:0] upper;
    slot  = p / SLOT;
    w     = p % SLOT;
    n     = '0;
    e     = '0;
    upper = act >> (4 * slot);
    if (w >= BLANK_CYC) begin
      n = upper[3:0];
      if (!blk && !(slot > 0 && upper == 16'h0)) e = 4'(1 << slot);
    end
    return {n, e, (e != 4'h0), (p == FRAME - 1), !pf};
  endfunction

  task automatic model_reset();
    m_pos     = 0;
    m_active  = '0;
    m_pending = '0;
    m_pfull   = 1'b0;
  endtask

  // Advance the model across the coming edge and queue the expected outputs.
  task automatic model_step(input logic v, input logic [15:0] d, input logic blk);
    logic fd_b, rdy_b;
    exp_t e;
    fd_b  = (m_pos == FRAME - 1);
    rdy_b = !m_pfull;
    if (fd_b && m_pfull) begin
      m_active = m_pending;
      m_pfull  = 1'b0;
    end
    if (v && rdy_b) begin
      m_pending = d;
      m_pfull   = 1'b1;
    end
    m_pos = (m_pos + 1) % FRAME;
    e.cyc = cyc + 1;
    e.v   = model_out(m_pos, m_active, m_pfull, blk);
    exp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL stale_expectation t=%0t entry cycle %0d, monitor cycle %0d", $time, e.cyc, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check("cycle_outputs", {nib, den, seg_en, fdone, ready}, e.v);
      end
    end
  end

  // Driver
  initial begin
    int n_rst;
    int sel;
    logic [15:0] r;
    n_rst = 0;
    #1 rst_n = 1'b0;
    #2 check("reset_initial", {nib, den, seg_en, fdone, ready}, RST_VEC);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < NCYC; i++) begin
      // Stimulus for the coming edge.
      if ($urandom_range(0, 99) < 2) blank = ~blank;
      if (m_pos == FRAME - 1 && !m_pfull)
        valid = ($urandom_range(0, 1) == 1);
      else if (((i / 300) % 2) == 1)
        valid = ($urandom_range(0, 39) == 0);
      else
        valid = ($urandom_range(0, 2) == 0);
      sel = $urandom_range(0, 4);
      r   = 16'($urandom);
      case (sel)
        2:       data = r & 16'h00FF;
        3:       data = r & 16'h000F;
        4:       data = r[0] ? 16'h0050 : 16'h0000;
        default: data = r;
      endcase
      model_step(valid, data, blank);

      @(posedge clk);
      #1;
      // Asynchronous reset, mostly while digit2 is lit.
      if ((m_pos == 2 * SLOT + BLANK_CYC + 1 && n_rst < 6 && $urandom_range(0, 3) == 0) ||
          $urandom_range(0, 999) == 0) begin
        n_rst++;
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", {nib, den, seg_en, fdone, ready}, RST_VEC);
        exp_q.delete();
        model_reset();
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1 check("reset_held", {nib, den, seg_en, fdone, ready}, RST_VEC);
        rst_n = 1'b1;
      end
    end

    valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain %0d entries left, expected 0", exp_q.size());
    end
    n_cmp++;
    if (n_rst == 0) begin
      n_bad++;
      $display("FAIL reset_coverage %0d resets issued, expected at least 1", n_rst);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
